ram_sequencer: RTL

RAM_SEQUENCER -- requirements
Module: ram_sequencer

---
 rtl/ram_sequencer_pkg.sv | 20 ++
 rtl/ram_sequencer_dwell.sv | 28 ++
 rtl/ram_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ram_sequencer_pkg.sv
// Shared types and sizing for the RAM fill/scan sequencer.
// Holds the FSM state encoding and the RAM geometry.
package ram_sequencer_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD_ADDR,
        S_RD_WAIT,
        S_SHOW,
        S_DONE
    } state_t;

endpackage

// File: rtl/ram_sequencer_dwell.sv
// Loadable down-counter with zero flag, used to time how long each scanned value is shown.
// Zero-latency flag: zero reflects the current count; counting stops at zero.
module dwell_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ram_sequencer.sv
// Fills a 32x8 RAM with seed+address, or scans it out to a display one value at a time.
// FILL takes 32 cycles; SCAN takes 32*(2+DWELL) cycles; start is ignored while busy.
module ram_sequencer
    import ram_sequencer_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] q_in,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_valid,
    output logic              busy,
    output logic              done
);

    // The counter is loaded with DWELL-1 so that SHOW lasts DWELL cycles
    // including the cycle in which the zero flag is seen.
    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] seed_q;
    logic              dwell_load;
    logic              dwell_dec;
    logic              dwell_zero;

    dwell_counter #(.W(8)) u_dwell (
        .clock    (clock),
        .resetn   (resetn),
        .load     (dwell_load),
        .dec      (dwell_dec),
        .load_val (DWELL_LOAD),
        .zero     (dwell_zero)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dwell_load = 1'b0;
        dwell_dec  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = mode ? S_FILL : S_RD_ADDR;
                end
            end
            S_FILL: begin
                if (addr == LAST_ADDR) begin
                    state_nxt = S_DONE;
                end
            end
            S_RD_ADDR: begin
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                dwell_load = 1'b1;
                state_nxt  = S_SHOW;
            end
            S_SHOW: begin
                if (dwell_zero) begin
                    state_nxt = (addr == LAST_ADDR) ? S_DONE : S_RD_ADDR;
                end else begin
                    dwell_dec = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The address stops at 31 and is cleared on the way into DONE, so it never wraps within an operation.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr       <= '0;
            seed_q     <= '0;
            disp_value <= '0;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr   <= '0;
                        seed_q <= seed;
                        if (!mode) begin
                            disp_valid <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                end
                S_RD_WAIT: begin
                    disp_value <= q_in;
                    disp_valid <= 1'b1;
                end
                S_SHOW: begin
                    if (dwell_zero) begin
                        addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                    end
                end
                S_DONE: begin
                    addr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Decoded straight from state so that reset drops wren without waiting for a clock edge.
    assign wren    = (state == S_FILL);
    assign data    = wren ? (seed_q + DATA_W'(addr)) : '0;
    assign address = addr;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule
